hbridge_deadtime: RTL

- Downstream stage of the Avalon PWM controller. It takes the two-leg drive pair and produces four gate signals for a full H-bridge: high and low side per leg.
- Inserts a programmable dead-time on every leg transition.
- Has a latched, software-cleared fault shutdown and a master enable.
- Sits between the PWM controller and the gate-driver pins, with its own small Avalon slave for configuration.

---
 rtl/hbridge_deadtime.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/hbridge_deadtime.sv
// H-bridge gate stage: turns a two-leg PWM drive into four gate enables with
// programmable dead-time, a latched fault shutdown and a master enable.

module hbridge_deadtime_leg #(
  parameter int DT_W = 8
) (
  input  logic            a_50_MHZ_CLK,
  input  logic            reset_n,
  input  logic            kill,
  input  logic            pwm,
  input  logic [DT_W-1:0] load_val,
  output logic            gate_hi,
  output logic            gate_lo,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DT_HI = 3'd1,
    S_HI    = 3'd2,
    S_DT_LO = 3'd3,
    S_LO    = 3'd4
  } leg_state_e;

  leg_state_e        cur_state;
  leg_state_e        next_state;
  logic [DT_W-1:0]   cnt;
  logic [DT_W-1:0]   cnt_next;

  always_ff @(posedge a_50_MHZ_CLK or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= S_OFF;
      cnt       <= '0;
      gate_hi   <= 1'b0;
      gate_lo   <= 1'b0;
    end else begin
      cur_state <= next_state;
      cnt       <= cnt_next;
      // Gates are flops decoded from the next state, so a leg can never
      // assert both sides and the pins carry no decode glitches.
      gate_hi   <= (next_state == S_HI);
      gate_lo   <= (next_state == S_LO);
    end
  end

  always_comb begin
    next_state = cur_state;
    cnt_next   = cnt;
    if (kill) begin
      next_state = S_OFF;
    end else begin
      case (cur_state)
        S_OFF: begin
          next_state = pwm ? S_DT_HI : S_DT_LO;
          cnt_next   = load_val;
        end
        S_DT_HI: begin
          // Abort goes straight back: the low side is still the safe side.
          if (!pwm)              next_state = S_LO;
          else if (cnt == '0)    next_state = S_HI;
          else                   cnt_next   = cnt - DT_W'(1);
        end
        S_HI: begin
          if (!pwm) begin
            next_state = S_DT_LO;
            cnt_next   = load_val;
          end
        end
        S_DT_LO: begin
          if (pwm)               next_state = S_HI;
          else if (cnt == '0)    next_state = S_LO;
          else                   cnt_next   = cnt - DT_W'(1);
        end
        S_LO: begin
          if (pwm) begin
            next_state = S_DT_HI;
            cnt_next   = load_val;
          end
        end
        default: next_state = S_OFF;
      endcase
    end
  end

  assign state = cur_state;

endmodule

module hbridge_deadtime #(
  parameter int DT_W       = 8,
  parameter int DEFAULT_DT = 10
) (
  input  logic        a_50_MHZ_CLK,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [1:0]  pwm_in,
  input  logic        fault_n,
  output logic [1:0]  gate_hi,
  output logic [1:0]  gate_lo,
  output logic        fault
);

  logic [DT_W-1:0]  dead_time;
  logic [DT_W-1:0]  dt_load;
  logic             enable;
  logic             sync1;
  logic             sync2;
  logic             fault_s;
  logic             wr;
  logic             kill;
  logic [1:0][2:0]  leg_state;
  logic             unused_wdata;

  assign wr           = chipselect && !write_n;
  assign fault_s      = ~sync2;
  assign kill         = fault || fault_s || !enable;
  assign unused_wdata = ^writedata[31:DT_W];
  // A zero register still yields one all-off cycle.
  assign dt_load      = (dead_time == '0) ? '0 : dead_time - DT_W'(1);

  always_ff @(posedge a_50_MHZ_CLK or negedge reset_n) begin
    if (!reset_n) begin
      dead_time <= DT_W'(DEFAULT_DT);
      enable    <= 1'b0;
      fault     <= 1'b0;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
    end else begin
      sync1 <= fault_n;
      sync2 <= sync1;
      if (wr && address == 2'd0) dead_time <= writedata[DT_W-1:0];
      if (wr && address == 2'd1) enable    <= writedata[0];
      // Set has priority over a clear landing in the same cycle.
      if (fault_s)
        fault <= 1'b1;
      else if (wr && address == 2'd1 && writedata[1])
        fault <= 1'b0;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_leg
    hbridge_deadtime_leg #(.DT_W(DT_W)) u_leg (
      .a_50_MHZ_CLK (a_50_MHZ_CLK),
      .reset_n      (reset_n),
      .kill         (kill),
      .pwm          (pwm_in[g]),
      .load_val     (dt_load),
      .gate_hi      (gate_hi[g]),
      .gate_lo      (gate_lo[g]),
      .state        (leg_state[g])
    );
  end

  always_ff @(posedge a_50_MHZ_CLK or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(dead_time);
        2'd1:    readdata <= {30'b0, fault, enable};
        2'd2:    readdata <= {26'b0, leg_state[1], leg_state[0]};
        default: readdata <= '0;
      endcase
    end
  end

endmodule
